// File: rtl/axi4_resp_pkg.sv
// Shared types for the AXI4 read responder: burst encodings, default widths,
// and the packed AR request / R beat records carried through the queues.
package axi4_resp_pkg;

  localparam int DEF_ID_W        = 3;
  localparam int DEF_ADDR_W      = 31;
  localparam int DEF_DATA_W      = 64;
  localparam int BEAT_BYTES_LOG2 = 3;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } fsm_state_e;

  typedef struct packed {
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            echo_size;
    logic [2:0]            echo_source;
  } ar_req_t;

  typedef struct packed {
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_DATA_W-1:0] data;
    logic [3:0]            echo_size;
    logic [2:0]            echo_source;
    logic                  last;
  } r_beat_t;

  // Beats are at most 8 bytes wide, so larger sizes step like size 3.
  function automatic logic [1:0] clamp_size(input logic [2:0] size);
    return (size > 3'd3) ? 2'd3 : size[1:0];
  endfunction

endpackage

// File: rtl/axi4_read_responder_beat_queue.sv
// Generic FIFO used for both the AR request queue and the R output buffer.
// Valid/ready: a transfer happens on a side in any cycle where valid && ready.
module axi4_beat_queue #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     out_data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready_o  = (count_q != CNT_W'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  // Storage is cleared on reset so an empty queue presents an all-zero head.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= inc_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= inc_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axi4_read_responder.sv
// AXI4 read-side responder: queues AR requests, walks each burst issuing one
// 1-cycle-latency memory read per beat, and returns the data as R beats.
module axi4_read_responder
  import axi4_resp_pkg::*;
#(
  parameter int ID_W     = DEF_ID_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int AR_DEPTH = 2,
  parameter int R_DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  output logic              auto_in_arready,
  input  logic              auto_in_arvalid,
  input  logic [ID_W-1:0]   auto_in_arid,
  input  logic [ADDR_W-1:0] auto_in_araddr,
  input  logic [7:0]        auto_in_arlen,
  input  logic [2:0]        auto_in_arsize,
  input  logic [1:0]        auto_in_arburst,
  input  logic [3:0]        auto_in_arecho_tl_state_size,
  input  logic [2:0]        auto_in_arecho_tl_state_source,
  input  logic              auto_in_rready,
  output logic              auto_in_rvalid,
  output logic [ID_W-1:0]   auto_in_rid,
  output logic [DATA_W-1:0] auto_in_rdata,
  output logic [3:0]        auto_in_recho_tl_state_size,
  output logic [2:0]        auto_in_recho_tl_state_source,
  output logic              auto_in_rlast,
  output logic              mem_ren,
  output logic [ADDR_W-4:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dbg_state_o
);

  localparam int AC_W = $clog2(AR_DEPTH + 1);
  localparam int RC_W = $clog2(R_DEPTH + 1);
  localparam logic [RC_W:0] R_CAP = (RC_W + 1)'(R_DEPTH);

  ar_req_t           ar_in;
  ar_req_t           ar_head;
  logic              ar_head_valid;
  logic              ar_pop;
  logic [AC_W-1:0]   ar_count;

  r_beat_t           r_in;
  r_beat_t           r_head;
  logic              r_head_valid;
  logic              r_pop;
  logic              r_in_ready;
  logic [RC_W-1:0]   r_count;

  fsm_state_e        state_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        len_q;
  logic [1:0]        size_q;
  logic [1:0]        burst_q;
  logic [3:0]        esz_q;
  logic [2:0]        esrc_q;
  logic [7:0]        beat_q;
  logic              inflight_q;
  logic [ID_W-1:0]   tag_id_q;
  logic [3:0]        tag_esz_q;
  logic [2:0]        tag_esrc_q;
  logic              tag_last_q;

  logic [RC_W:0]     occ;
  logic              credit;
  logic              issue;
  logic              beat_last;
  logic              unused_ok;

  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] a,
    input logic [7:0]        len,
    input logic [1:0]        sz,
    input logic [1:0]        burst
  );
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] sum;
    logic [ADDR_W-1:0] mask;
    logic              wrap_ok;
    incr    = ADDR_W'(1) << sz;
    sum     = a + incr;
    mask    = ((ADDR_W'(len) + ADDR_W'(1)) << sz) - ADDR_W'(1);
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    case (burst)
      BURST_FIXED: next_addr = a;
      BURST_WRAP:  next_addr = wrap_ok ? ((a & ~mask) | (sum & mask)) : sum;
      default:     next_addr = sum;
    endcase
  endfunction

  assign ar_in = '{
    id:          auto_in_arid,
    addr:        auto_in_araddr,
    len:         auto_in_arlen,
    size:        auto_in_arsize,
    burst:       auto_in_arburst,
    echo_size:   auto_in_arecho_tl_state_size,
    echo_source: auto_in_arecho_tl_state_source
  };

  axi4_beat_queue #(
    .W     ($bits(ar_req_t)),
    .DEPTH (AR_DEPTH)
  ) u_ar_queue (
    .clk_i       (clock),
    .rst_i       (reset),
    .in_valid_i  (auto_in_arvalid),
    .in_ready_o  (auto_in_arready),
    .in_data_i   (ar_in),
    .out_valid_o (ar_head_valid),
    .out_ready_i (ar_pop),
    .out_data_o  (ar_head),
    .count_o     (ar_count)
  );

  // Credit counts buffered beats plus the read whose data lands next cycle,
  // so the R buffer can never be written while full.
  assign r_pop     = r_head_valid && auto_in_rready;
  assign occ       = {1'b0, r_count} + (RC_W + 1)'(inflight_q) - (RC_W + 1)'(r_pop);
  assign credit    = (occ < R_CAP);
  assign issue     = (state_q == ST_BURST) && credit;
  assign beat_last = (beat_q == len_q);
  assign ar_pop    = (state_q == ST_IDLE) && ar_head_valid;
  assign addr_d    = next_addr(addr_q, len_q, size_q, burst_q);

  assign mem_ren     = issue;
  assign mem_addr    = addr_q[ADDR_W-1:BEAT_BYTES_LOG2];
  assign dbg_state_o = state_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      esz_q      <= '0;
      esrc_q     <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      tag_id_q   <= '0;
      tag_esz_q  <= '0;
      tag_esrc_q <= '0;
      tag_last_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      case (state_q)
        ST_IDLE: begin
          if (ar_head_valid) begin
            id_q    <= ar_head.id;
            addr_q  <= ar_head.addr;
            len_q   <= ar_head.len;
            size_q  <= clamp_size(ar_head.size);
            burst_q <= ar_head.burst;
            esz_q   <= ar_head.echo_size;
            esrc_q  <= ar_head.echo_source;
            beat_q  <= '0;
            state_q <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (issue) begin
            tag_id_q   <= id_q;
            tag_esz_q  <= esz_q;
            tag_esrc_q <= esrc_q;
            tag_last_q <= beat_last;
            beat_q     <= beat_q + 8'd1;
            addr_q     <= addr_d;
            if (beat_last) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The tag registered at issue time meets its data one cycle later.
  assign r_in = '{
    id:          tag_id_q,
    data:        mem_rdata,
    echo_size:   tag_esz_q,
    echo_source: tag_esrc_q,
    last:        tag_last_q
  };

  axi4_beat_queue #(
    .W     ($bits(r_beat_t)),
    .DEPTH (R_DEPTH)
  ) u_r_buffer (
    .clk_i       (clock),
    .rst_i       (reset),
    .in_valid_i  (inflight_q),
    .in_ready_o  (r_in_ready),
    .in_data_i   (r_in),
    .out_valid_o (r_head_valid),
    .out_ready_i (auto_in_rready),
    .out_data_o  (r_head),
    .count_o     (r_count)
  );

  assign unused_ok = ^{ar_count, r_in_ready};

  assign auto_in_rvalid                = r_head_valid;
  assign auto_in_rid                   = r_head.id;
  assign auto_in_rdata                 = r_head.data;
  assign auto_in_recho_tl_state_size   = r_head.echo_size;
  assign auto_in_recho_tl_state_source = r_head.echo_source;
  assign auto_in_rlast                 = r_head.last;

endmodule

// File: tb/tb_axi4_read_responder.sv
// Bench for axi4_read_responder: synchronous memory model, AR driver task,
// and a scoreboard of expected mem addresses and R beats.
module tb_axi4_read_responder;

  logic        clock;
  logic        reset;
  logic        auto_in_arready;
  logic        auto_in_arvalid;
  logic [2:0]  auto_in_arid;
  logic [30:0] auto_in_araddr;
  logic [7:0]  auto_in_arlen;
  logic [2:0]  auto_in_arsize;
  logic [1:0]  auto_in_arburst;
  logic [3:0]  auto_in_arecho_tl_state_size;
  logic [2:0]  auto_in_arecho_tl_state_source;
  logic        auto_in_rready;
  logic        auto_in_rvalid;
  logic [2:0]  auto_in_rid;
  logic [63:0] auto_in_rdata;
  logic [3:0]  auto_in_recho_tl_state_size;
  logic [2:0]  auto_in_recho_tl_state_source;
  logic        auto_in_rlast;
  logic        mem_ren;
  logic [27:0] mem_addr;
  logic [63:0] mem_rdata;
  logic        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int r_beats = 0;
  logic sb_on   = 1'b1;
  logic rand_on = 1'b0;

  logic [74:0] exp_q[$];
  logic [27:0] exp_addr_q[$];
  logic [27:0] ren_addr_q[$];
  int          ren_cyc_q[$];
  int          r_cyc_q[$];

  axi4_read_responder dut (
    .clock                          (clock),
    .reset                          (reset),
    .auto_in_arready                (auto_in_arready),
    .auto_in_arvalid                (auto_in_arvalid),
    .auto_in_arid                   (auto_in_arid),
    .auto_in_araddr                 (auto_in_araddr),
    .auto_in_arlen                  (auto_in_arlen),
    .auto_in_arsize                 (auto_in_arsize),
    .auto_in_arburst                (auto_in_arburst),
    .auto_in_arecho_tl_state_size   (auto_in_arecho_tl_state_size),
    .auto_in_arecho_tl_state_source (auto_in_arecho_tl_state_source),
    .auto_in_rready                 (auto_in_rready),
    .auto_in_rvalid                 (auto_in_rvalid),
    .auto_in_rid                    (auto_in_rid),
    .auto_in_rdata                  (auto_in_rdata),
    .auto_in_recho_tl_state_size    (auto_in_recho_tl_state_size),
    .auto_in_recho_tl_state_source  (auto_in_recho_tl_state_source),
    .auto_in_rlast                  (auto_in_rlast),
    .mem_ren                        (mem_ren),
    .mem_addr                       (mem_addr),
    .mem_rdata                      (mem_rdata),
    .dbg_state_o                    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- models ----------------
  function automatic logic [63:0] data_of(input logic [27:0] a);
    return {8'hC3, a, a ^ 28'h5A5A5A5};
  endfunction

  function automatic logic [30:0] model_addr(input logic [30:0] start, input int k,
                                             input int len, input int size, input int burst);
    longint incr;
    longint total;
    longint off;
    longint s;
    int     sz;
    sz   = (size > 3) ? 3 : size;
    incr = longint'(1) << sz;
    s    = longint'(start);
    if (burst == 0) return start;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      total = longint'(len + 1) * incr;
      off   = s % total;
      return 31'((s - off) + ((off + longint'(k) * incr) % total));
    end
    return 31'(s + longint'(k) * incr);
  endfunction

  // Synchronous memory: data for an accepted read shows up the next cycle.
  always @(posedge clock) begin
    if (mem_ren) mem_rdata <= data_of(mem_addr);
    else         mem_rdata <= {$urandom, $urandom};
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [74:0] r_payload();
    return {auto_in_rid, auto_in_rdata, auto_in_recho_tl_state_size,
            auto_in_recho_tl_state_source, auto_in_rlast};
  endfunction

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clock) begin
    logic [127:0] e;
    if (sb_on) begin
      if (mem_ren) begin
        ren_addr_q.push_back(mem_addr);
        ren_cyc_q.push_back(cyc);
        e = (exp_addr_q.size() > 0) ? 128'(exp_addr_q.pop_front()) : '1;
        check("mem_addr", 128'(mem_addr), e);
      end
      if (auto_in_rvalid && auto_in_rready) begin
        r_beats++;
        r_cyc_q.push_back(cyc);
        e = (exp_q.size() > 0) ? 128'(exp_q.pop_front()) : '1;
        check("r_beat", 128'(r_payload()), e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    ren_addr_q.delete();
    ren_cyc_q.delete();
    r_cyc_q.delete();
  endtask

  task automatic drive_ar(input int id, input logic [30:0] addr, input int len,
                          input int size, input int burst, input int esz, input int esrc);
    logic [30:0] a;
    logic        hs;
    int          n;
    for (int k = 0; k <= len; k++) begin
      a = model_addr(addr, k, len, size, burst);
      exp_addr_q.push_back(a[30:3]);
      exp_q.push_back({3'(id), data_of(a[30:3]), 4'(esz), 3'(esrc), (k == len)});
    end
    auto_in_arvalid                = 1'b1;
    auto_in_arid                   = 3'(id);
    auto_in_araddr                 = addr;
    auto_in_arlen                  = 8'(len);
    auto_in_arsize                 = 3'(size);
    auto_in_arburst                = 2'(burst);
    auto_in_arecho_tl_state_size   = 4'(esz);
    auto_in_arecho_tl_state_source = 3'(esrc);
    n  = 0;
    hs = 1'b0;
    do begin
      @(negedge clock);
      hs = auto_in_arready;
      @(posedge clock);
      #1;
      n++;
    end while (!hs && n < 400);
    auto_in_arvalid = 1'b0;
    check("ar_accept", 128'(hs), 128'(1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || exp_addr_q.size() > 0) && n < 600) begin
      tick();
      n++;
    end
    check("drain_r", 128'(exp_q.size()), 128'(0));
    check("drain_mem", 128'(exp_addr_q.size()), 128'(0));
    repeat (2) tick();
  endtask

  task automatic check_addrs(input string tag, input logic [27:0] a0, input logic [27:0] a1,
                             input logic [27:0] a2, input logic [27:0] a3, input int cnt);
    logic [27:0] tbl [4];
    tbl[0] = a0; tbl[1] = a1; tbl[2] = a2; tbl[3] = a3;
    check({tag, "_count"}, 128'(ren_addr_q.size()), 128'(cnt));
    for (int i = 0; i < cnt; i++)
      check(tag, (i < ren_addr_q.size()) ? 128'(ren_addr_q[i]) : '1, 128'(tbl[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          n;
    int          base;
    logic [74:0] p0;
    logic [31:0] ra;

    reset = 1'b1;
    auto_in_arvalid = 1'b0;
    auto_in_arid = '0;
    auto_in_araddr = '0;
    auto_in_arlen = '0;
    auto_in_arsize = '0;
    auto_in_arburst = '0;
    auto_in_arecho_tl_state_size = '0;
    auto_in_arecho_tl_state_source = '0;
    auto_in_rready = 1'b0;
    repeat (3) tick();
    check("rst_rvalid", 128'(auto_in_rvalid), 128'(0));
    check("rst_mem_ren", 128'(mem_ren), 128'(0));
    check("rst_arready", 128'(auto_in_arready), 128'(1));
    check("rst_rlast", 128'(auto_in_rlast), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(0));
    reset = 1'b0;
    tick();

    // Single beat and AR-to-R latency
    auto_in_rready = 1'b1;
    clear_logs();
    drive_ar(5, 31'h100, 0, 3, 1, 6, 2);
    n = 0;
    while (!auto_in_rvalid && n < 20) begin
      tick();
      n++;
    end
    check("single_latency", 128'(n), 128'(3));
    check("single_rlast", 128'(auto_in_rlast), 128'(1));
    check("single_rid", 128'(auto_in_rid), 128'(5));
    wait_drain();
    check_addrs("single_addr", 28'h20, 28'h0, 28'h0, 28'h0, 1);

    // INCR 4 beats at full rate
    clear_logs();
    drive_ar(1, 31'h40, 3, 3, 1, 2, 1);
    wait_drain();
    check_addrs("incr_addr", 28'h8, 28'h9, 28'hA, 28'hB, 4);
    check("incr_ren_span", (ren_cyc_q.size() == 4) ? 128'(ren_cyc_q[3] - ren_cyc_q[0]) : '1, 128'(3));
    check("incr_r_span", (r_cyc_q.size() == 4) ? 128'(r_cyc_q[3] - r_cyc_q[0]) : '1, 128'(3));

    // WRAP and FIXED
    clear_logs();
    drive_ar(2, 31'h18, 3, 3, 2, 3, 3);
    wait_drain();
    check_addrs("wrap_addr", 28'h3, 28'h0, 28'h1, 28'h2, 4);
    clear_logs();
    drive_ar(3, 31'h88, 2, 3, 0, 1, 1);
    wait_drain();
    check_addrs("fixed_addr", 28'h11, 28'h11, 28'h11, 28'h0, 3);

    // Backpressure during an 8-beat burst
    auto_in_rready = 1'b0;
    clear_logs();
    drive_ar(6, 31'h1000, 7, 3, 1, 5, 4);
    repeat (10) tick();
    check("bp_ren_count", 128'(ren_addr_q.size()), 128'(2));
    check("bp_rvalid", 128'(auto_in_rvalid), 128'(1));
    p0 = r_payload();
    check("bp_head", 128'(p0), 128'(exp_q[0]));
    repeat (4) tick();
    check("bp_stable", 128'(r_payload()), 128'(p0));
    auto_in_rready = 1'b1;
    wait_drain();
    check("bp_beats", 128'(r_cyc_q.size()), 128'(8));

    // AR queue fills while the first burst is stalled
    auto_in_rready = 1'b0;
    clear_logs();
    drive_ar(1, 31'h2000, 3, 3, 1, 1, 1);
    drive_ar(2, 31'h3000, 3, 3, 1, 2, 2);
    drive_ar(3, 31'h4000, 3, 3, 1, 3, 3);
    check("arq_full", 128'(auto_in_arready), 128'(0));
    repeat (3) tick();
    check("arq_full_hold", 128'(auto_in_arready), 128'(0));
    auto_in_rready = 1'b1;
    wait_drain();
    check("arq_beats", 128'(r_cyc_q.size()), 128'(12));

    // Reset in the middle of a burst
    base = r_beats;
    drive_ar(4, 31'h200, 3, 3, 1, 7, 5);
    n = 0;
    while ((r_beats - base) < 2 && n < 50) begin
      tick();
      n++;
    end
    check("mid_rst_beats", 128'(r_beats - base), 128'(2));
    reset = 1'b1;
    sb_on = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    tick();
    check("mid_rst_rvalid", 128'(auto_in_rvalid), 128'(0));
    check("mid_rst_mem_ren", 128'(mem_ren), 128'(0));
    check("mid_rst_arready", 128'(auto_in_arready), 128'(1));
    reset = 1'b0;
    tick();
    sb_on = 1'b1;
    clear_logs();
    drive_ar(7, 31'h300, 1, 3, 1, 2, 6);
    wait_drain();
    check("post_rst_beats", 128'(r_cyc_q.size()), 128'(2));

    // Random bursts with random rready
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          tick();
          auto_in_rready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      drive_ar($urandom_range(0, 7), ra[30:0], $urandom_range(0, 15), $urandom_range(0, 4),
               $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7));
    end
    rand_on = 1'b0;
    tick();
    tick();
    auto_in_rready = 1'b1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
